// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory responder: FSM state encoding, frame geometry, range helper.
// Latency: n/a (definitions only).
// Backpressure: n/a; the SPI link has no flow control, the controller polls mem_ready/mem_done.
package spi_mem_pkg;

   localparam int MEM_DEPTH     = 32;
   localparam int WR_FRAME_BITS = 17;  // rw + addr[6:0] + addr[7] + data[7:0]
   localparam int RD_CMD_BITS   = 8;   // rw + addr[6:0]
   localparam int RD_DATA_BITS  = 8;
   // Bits that follow the command byte in a write frame: addr[7] + data[7:0].
   localparam int WR_TAIL_BITS  = WR_FRAME_BITS - RD_CMD_BITS;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_RX_CMD   = 3'd2,
      ST_RX_WDATA = 3'd3,
      ST_WRITE    = 3'd4,
      ST_RD_PREP  = 3'd5,
      ST_TX_DATA  = 3'd6,
      ST_WAIT_CS  = 3'd7
   } spi_slv_state_t;

   // True when a frame address selects an implemented word.
   function automatic logic addr_in_range(input logic [7:0] addr, input int depth);
      return (32'(addr) < depth);
   endfunction

endpackage

// File: rtl/spi_mem_array.sv
// DEPTH x DW register file: one synchronous write port, one combinational read port, sync reset to zero.
// Latency: write visible on rdata the cycle after the we edge; read is combinational.
// Backpressure: none; a write is accepted on every cycle we is high.
// Ports: clk/rst (sync, active-high), we/waddr/wdata write port, raddr/rdata read port.
module spi_mem_array
   import spi_mem_pkg::*;
#(
   parameter int DEPTH  = MEM_DEPTH,
   parameter int DW     = 8,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DW-1:0]     wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DW-1:0]     rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Callers guarantee raddr < DEPTH before using the result.
   assign rdata = mem[raddr];

endmodule

// File: rtl/spi_mem_slave.sv
// SPI responder for the on-chip register memory: deserialises LSB-first frames while cs is low,
// commits writes, serialises reads on miso. Latency: write commit + mem_done one edge after the
// last frame bit; mem_ready one edge after the command byte, read data on the 8 edges after that.
// Backpressure: none; cs high mid-frame aborts back to IDLE with no side effects.
// Ports: clk/rst (sync, active-high), cs (active low), mosi in; miso, mem_ready, mem_done, addr_err out.
module spi_mem_slave
   import spi_mem_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH,
   parameter int DW    = 8,
   parameter int AW    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic cs,
   input  logic mosi,
   output logic miso,
   output logic mem_ready,
   output logic mem_done,
   output logic addr_err
);

   localparam int         MAW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] CMD_LAST = 5'(RD_CMD_BITS - 1);
   localparam logic [4:0] WR_LAST  = 5'(WR_TAIL_BITS - 1);
   localparam logic [4:0] TX_LAST  = 5'(RD_DATA_BITS - 1);

   spi_slv_state_t state;
   spi_slv_state_t cur;
   logic [4:0]     cnt;
   logic [AW-1:0]  addr;
   logic [DW-1:0]  wdata;
   logic [DW-1:0]  sreg;
   logic [DW-1:0]  rdata;
   logic [8:0]     rx_sr;
   logic [8:0]     rx_next;
   logic           addr_ok;
   logic           we;

   // The setup (discard) edge is the very first edge that sees cs low, so an IDLE
   // cycle with cs low is handled as SETUP in place rather than one edge later.
   always_comb begin
      cur = state;
      if (state == ST_IDLE && !cs) begin
         cur = ST_SETUP;
      end
   end

   // Receive shifter: newest bit enters at the top, so after N shifts the first
   // bit of the field sits at position 9-N.
   assign rx_next = {mosi, rx_sr[8:1]};
   assign addr_ok = addr_in_range(addr, DEPTH);
   // cs high in WRITE is an abort, so the commit is gated on cs as well.
   assign we      = (state == ST_WRITE) && !cs && addr_ok;

   spi_mem_array #(
      .DEPTH (DEPTH),
      .DW    (DW),
      .ADDR_W(MAW)
   ) u_array (
      .clk  (clk),
      .rst  (rst),
      .we   (we),
      .waddr(addr[MAW-1:0]),
      .wdata(wdata),
      .raddr(addr[MAW-1:0]),
      .rdata(rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         addr      <= '0;
         wdata     <= '0;
         sreg      <= '0;
         rx_sr     <= '0;
         miso      <= 1'b0;
         mem_ready <= 1'b0;
         mem_done  <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         mem_ready <= 1'b0;
         mem_done  <= 1'b0;
         addr_err  <= 1'b0;

         if (cs && state != ST_IDLE && state != ST_WAIT_CS) begin
            // Abort: controller released cs mid-frame.
            state <= ST_IDLE;
            cnt   <= '0;
            miso  <= 1'b0;
         end else begin
            case (cur)
               ST_IDLE: begin
                  cnt  <= '0;
                  miso <= 1'b0;
               end

               ST_SETUP: begin
                  // mosi on this edge is controller setup time, not frame data.
                  addr  <= '0;
                  cnt   <= '0;
                  miso  <= 1'b0;
                  state <= ST_RX_CMD;
               end

               ST_RX_CMD: begin
                  rx_sr <= rx_next;
                  if (cnt == CMD_LAST) begin
                     // rx_next[1] = rw, rx_next[8:2] = addr[6:0]; addr[7] stays 0 for reads.
                     addr  <= {1'b0, rx_next[8:2]};
                     cnt   <= '0;
                     state <= rx_next[1] ? ST_RX_WDATA : ST_RD_PREP;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end

               ST_RX_WDATA: begin
                  rx_sr <= rx_next;
                  if (cnt == WR_LAST) begin
                     // rx_next[0] = addr[7], rx_next[8:1] = data[7:0].
                     addr[AW-1] <= rx_next[0];
                     wdata      <= rx_next[8:1];
                     cnt        <= '0;
                     state      <= ST_WRITE;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end

               ST_WRITE: begin
                  // Commit happens through we; the handshake pulses even for a bad address.
                  mem_done <= 1'b1;
                  addr_err <= !addr_ok;
                  state    <= ST_WAIT_CS;
               end

               ST_RD_PREP: begin
                  sreg      <= addr_ok ? rdata : '0;
                  mem_ready <= 1'b1;
                  addr_err  <= !addr_ok;
                  cnt       <= '0;
                  state     <= ST_TX_DATA;
               end

               ST_TX_DATA: begin
                  miso <= sreg[0];
                  sreg <= sreg >> 1;
                  if (cnt == TX_LAST) begin
                     cnt   <= '0;
                     state <= ST_WAIT_CS;
                  end else begin
                     cnt <= cnt + 5'd1;
                  end
               end

               ST_WAIT_CS: begin
                  // Extra mosi bits while cs stays low are ignored.
                  miso <= 1'b0;
                  if (cs) begin
                     cnt   <= '0;
                     state <= ST_IDLE;
                  end
               end

               default: begin
                  cnt   <= '0;
                  miso  <= 1'b0;
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
